int_exc_arbiter: RTL and testbench

Sequencing front-end for the pipeline's interrupt/exception control logic. It synchronizes and masks the six hardware interrupt lines, arbitrates them against M-stage exceptions, and issues a single-cycle take request with ExcCode. It tracks handler state (EXL) and enforces a post-`eret` guard window before interrupts are re-enabled. It sits between the CP0 status/cause fields, the M-stage exception logic and the flush/PC-select controller.

---
 rtl/int_exc_arbiter.sv | 151 +++++++++++++++
 tb/tb_int_exc_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_exc_arbiter.sv
// int_exc_arbiter
//   Interrupt/exception sequencing front-end. It registers (and optionally
//   synchronizes) the six hardware interrupt lines and masks them with SR.IM.
//   It arbitrates pending interrupts against M-stage exceptions and issues a
//   single-cycle take request with its ExcCode. It also tracks handler state
//   (EXL) and holds interrupts off for a guard window after eret.
//
//   Optional feature macro: INT_SYNC_EN
//     defined   : hw_int -> sync flop -> masked cause_ip register (2 cycles)
//     undefined : hw_int -> masked cause_ip register (1 cycle)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   hw_int[5:0]    raw level-sensitive interrupt lines
//   im[5:0]        SR.IM interrupt mask, 1 = enabled
//   ie             SR.IE global interrupt enable
//   m_valid        M stage holds a real instruction
//   exc_valid      exception detected on the M-stage instruction
//   exc_code[4:0]  ExcCode of that exception
//   eret_m         M-stage instruction is eret
//   int_exc_req    take request (combinational)
//   epc_we         write EPC this cycle (combinational)
//   cause_exccode  registered ExcCode of the last take
//   cause_ip       registered synchronized, masked pending lines
//   int_id         highest pending line index at the last interrupt take
//   exl            handler active
module int_exc_arbiter #(
   parameter int unsigned GUARD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] hw_int,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       m_valid,
   input  logic       exc_valid,
   input  logic [4:0] exc_code,
   input  logic       eret_m,
   output logic       int_exc_req,
   output logic       epc_we,
   output logic [4:0] cause_exccode,
   output logic [5:0] cause_ip,
   output logic [2:0] int_id,
   output logic       exl
);

   typedef enum logic [1:0] {IDLE, TAKE, HANDLER, GUARD} state_t;

   localparam logic [3:0] GUARD_LOAD =
      (GUARD_CYCLES == 0) ? 4'd0 : 4'(GUARD_CYCLES - 1);

   state_t     state, state_next;
   logic [3:0] guard_cnt, guard_cnt_next;
   logic [5:0] pend;
   logic [2:0] hi_id;
   logic       irq_take, exc_take;
   logic [4:0] take_code;

   // Pending lines as seen by the arbiter are the registered cause_ip value.
   assign pend = cause_ip;

`ifdef INT_SYNC_EN
   logic [5:0] sync1;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= '0;
         cause_ip <= '0;
      end else begin
         sync1    <= hw_int;
         cause_ip <= sync1 & im;
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cause_ip <= '0;
      else       cause_ip <= hw_int & im;
   end
`endif

   assign irq_take = ie & (|pend) & m_valid & (state == IDLE);
   assign exc_take = exc_valid & m_valid & (state != TAKE);

   // Highest set index of pend, bit 5 wins.
   always_comb begin
      hi_id = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         if (pend[i]) hi_id = 3'(i);
      end
   end

   // State register and take-related registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         guard_cnt     <= '0;
         cause_exccode <= '0;
         int_id        <= '0;
      end else begin
         state     <= state_next;
         guard_cnt <= guard_cnt_next;
         if (int_exc_req) cause_exccode <= take_code;
         if (irq_take && !exc_take) int_id <= hi_id;
      end
   end

   // Next-state logic
   always_comb begin
      state_next     = state;
      guard_cnt_next = guard_cnt;
      unique case (state)
         IDLE: begin
            if (irq_take || exc_take) state_next = TAKE;
         end
         TAKE: begin
            state_next = HANDLER;
         end
         HANDLER: begin
            if (exc_take) begin
               state_next = TAKE;
            end else if (eret_m && m_valid && !exc_valid) begin
               if (GUARD_CYCLES == 0) begin
                  state_next = IDLE;
               end else begin
                  state_next     = GUARD;
                  guard_cnt_next = GUARD_LOAD;
               end
            end
         end
         GUARD: begin
            if (exc_take) begin
               state_next = TAKE;
            end else if (guard_cnt == 4'd0) begin
               state_next = IDLE;
            end else begin
               guard_cnt_next = guard_cnt - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      exl         = (state == TAKE) || (state == HANDLER);
      int_exc_req = irq_take | exc_take;
      epc_we      = int_exc_req & ~exl;
      take_code   = exc_take ? exc_code : 5'd0;
   end

endmodule

// File: tb/tb_int_exc_arbiter.sv
module tb_int_exc_arbiter;

`ifdef INT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] hw_int;
   logic [5:0] im;
   logic       ie;
   logic       m_valid;
   logic       exc_valid;
   logic [4:0] exc_code;
   logic       eret_m;
   logic       int_exc_req;
   logic       epc_we;
   logic [4:0] cause_exccode;
   logic [5:0] cause_ip;
   logic [2:0] int_id;
   logic       exl;

   int total  = 0;
   int passed = 0;

   int_exc_arbiter #(.GUARD_CYCLES(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .hw_int        (hw_int),
      .im            (im),
      .ie            (ie),
      .m_valid       (m_valid),
      .exc_valid     (exc_valid),
      .exc_code      (exc_code),
      .eret_m        (eret_m),
      .int_exc_req   (int_exc_req),
      .epc_we        (epc_we),
      .cause_exccode (cause_exccode),
      .cause_ip      (cause_ip),
      .int_id        (int_id),
      .exl           (exl)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are then changed
   // and outputs sampled a further #1 later, well away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({int_exc_req, epc_we, exl, cause_exccode, cause_ip, int_id} !== 17'd0)
         $display("FAIL reset_async: got req=%b epc=%b exl=%b code=%0d ip=%b id=%0d, want all 0",
                  int_exc_req, epc_we, exl, cause_exccode, cause_ip, int_id);
      else passed++;
      step();
      step();
      #1;
      total++;
      if ({int_exc_req, exl, cause_ip} !== 8'd0)
         $display("FAIL reset_held: got req=%b exl=%b ip=%b, want 0", int_exc_req, exl, cause_ip);
      else passed++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_interrupt();
      hw_int = 6'b000100;
      for (int i = 0; i < LAT; i++) begin
         #1;
         total++;
         if (int_exc_req !== 1'b0)
            $display("FAIL irq_latency: cycle %0d got req=%b, want 0", i, int_exc_req);
         else passed++;
         step();
      end
      #1;
      total++;
      if ({int_exc_req, epc_we, cause_ip} !== {1'b1, 1'b1, 6'b000100})
         $display("FAIL irq_take: got req=%b epc=%b ip=%b, want 1 1 000100",
                  int_exc_req, epc_we, cause_ip);
      else passed++;
      step();
      hw_int = 6'd0;
      #1;
      total++;
      if ({int_exc_req, exl, cause_exccode, int_id} !== {1'b0, 1'b1, 5'd0, 3'd2})
         $display("FAIL irq_after: got req=%b exl=%b code=%0d id=%0d, want 0 1 0 2",
                  int_exc_req, exl, cause_exccode, int_id);
      else passed++;
      step();   // HANDLER
   endtask

   task automatic test_nested();
      exc_valid = 1'b1;
      exc_code  = 5'd4;
      #1;
      total++;
      if ({int_exc_req, epc_we, exl} !== 3'b101)
         $display("FAIL nested_req: got req=%b epc=%b exl=%b, want 1 0 1", int_exc_req, epc_we, exl);
      else passed++;
      step();   // TAKE, exc_valid still high: no request in TAKE
      #1;
      total++;
      if ({int_exc_req, exl, cause_exccode} !== {1'b0, 1'b1, 5'd4})
         $display("FAIL nested_take: got req=%b exl=%b code=%0d, want 0 1 4",
                  int_exc_req, exl, cause_exccode);
      else passed++;
      exc_valid = 1'b0;
      step();   // HANDLER
   endtask

   task automatic test_guard();
      hw_int = 6'b000100;
      for (int i = 0; i < LAT; i++) step();
      #1;
      total++;
      if ({int_exc_req, exl, cause_ip} !== {1'b0, 1'b1, 6'b000100})
         $display("FAIL handler_blocks_irq: got req=%b exl=%b ip=%b, want 0 1 000100",
                  int_exc_req, exl, cause_ip);
      else passed++;
      eret_m = 1'b1;
      step();   // GUARD, count 1
      eret_m = 1'b0;
      #1;
      total++;
      if ({int_exc_req, exl} !== 2'b00)
         $display("FAIL guard_c1: got req=%b exl=%b, want 0 0", int_exc_req, exl);
      else passed++;
      step();   // GUARD, count 0
      #1;
      total++;
      if (int_exc_req !== 1'b0)
         $display("FAIL guard_c2: got req=%b, want 0", int_exc_req);
      else passed++;
      step();   // IDLE
      #1;
      total++;
      if ({int_exc_req, epc_we} !== 2'b11)
         $display("FAIL guard_release: got req=%b epc=%b, want 1 1", int_exc_req, epc_we);
      else passed++;
      step();   // TAKE
      hw_int = 6'd0;
      step();   // HANDLER
      eret_m = 1'b1;
      step();   // GUARD
      eret_m    = 1'b0;
      exc_valid = 1'b1;
      exc_code  = 5'd7;
      #1;
      total++;
      if ({int_exc_req, epc_we, exl} !== 3'b110)
         $display("FAIL guard_exc: got req=%b epc=%b exl=%b, want 1 1 0", int_exc_req, epc_we, exl);
      else passed++;
      step();   // TAKE
      exc_valid = 1'b0;
      #1;
      total++;
      if ({exl, cause_exccode} !== {1'b1, 5'd7})
         $display("FAIL guard_exc_take: got exl=%b code=%0d, want 1 7", exl, cause_exccode);
      else passed++;
      step();   // HANDLER
      eret_m = 1'b1;
      step();   // GUARD
      eret_m = 1'b0;
      step();
      step();   // IDLE
   endtask

   task automatic test_exc_beats_irq();
      m_valid = 1'b0;
      hw_int  = 6'b100000;
      for (int i = 0; i < LAT; i++) step();
      #1;
      total++;
      if ({int_exc_req, exl, cause_ip} !== {1'b0, 1'b0, 6'b100000})
         $display("FAIL mvalid_hold: got req=%b exl=%b ip=%b, want 0 0 100000",
                  int_exc_req, exl, cause_ip);
      else passed++;
      m_valid   = 1'b1;
      exc_valid = 1'b1;
      exc_code  = 5'd12;
      #1;
      total++;
      if ({int_exc_req, epc_we} !== 2'b11)
         $display("FAIL exc_irq_req: got req=%b epc=%b, want 1 1", int_exc_req, epc_we);
      else passed++;
      step();   // TAKE
      exc_valid = 1'b0;
      hw_int    = 6'd0;
      #1;
      total++;
      if ({int_exc_req, cause_exccode, int_id} !== {1'b0, 5'd12, 3'd2})
         $display("FAIL exc_irq_after: got req=%b code=%0d id=%0d, want 0 12 2",
                  int_exc_req, cause_exccode, int_id);
      else passed++;
      step();   // HANDLER
      eret_m = 1'b1;
      step();   // GUARD
      eret_m = 1'b0;
      step();
      step();   // IDLE
   endtask

   task automatic test_masking();
      im     = 6'd0;
      hw_int = 6'h3F;
      for (int i = 0; i <= LAT; i++) step();
      #1;
      total++;
      if ({int_exc_req, cause_ip} !== 7'd0)
         $display("FAIL im_mask: got req=%b ip=%b, want 0 000000", int_exc_req, cause_ip);
      else passed++;
      im = 6'h3F;
      ie = 1'b0;
      for (int i = 0; i < LAT; i++) step();
      #1;
      total++;
      if ({int_exc_req, cause_ip} !== {1'b0, 6'h3F})
         $display("FAIL ie_mask: got req=%b ip=%b, want 0 111111", int_exc_req, cause_ip);
      else passed++;
      ie        = 1'b1;
      m_valid   = 1'b0;
      exc_valid = 1'b1;
      exc_code  = 5'd10;
      #1;
      total++;
      if ({int_exc_req, epc_we} !== 2'b00)
         $display("FAIL mvalid_suppress: got req=%b epc=%b, want 0 0", int_exc_req, epc_we);
      else passed++;
      m_valid   = 1'b1;
      exc_valid = 1'b0;
      #1;
      total++;
      if (int_exc_req !== 1'b1)
         $display("FAIL irq_unmasked: got req=%b, want 1", int_exc_req);
      else passed++;
      step();   // TAKE
      #1;
      total++;
      if ({int_id, cause_exccode} !== {3'd5, 5'd0})
         $display("FAIL irq_hi_id: got id=%0d code=%0d, want 5 0", int_id, cause_exccode);
      else passed++;
      step();   // HANDLER
   endtask

   task automatic test_reset_mid();
      exc_valid = 1'b1;
      exc_code  = 5'd9;
      step();   // TAKE
      exc_valid = 1'b0;
      step();   // HANDLER, hw_int still 3F so cause_ip nonzero
      #1;
      total++;
      if ({exl, cause_exccode, cause_ip} !== {1'b1, 5'd9, 6'h3F})
         $display("FAIL pre_reset: got exl=%b code=%0d ip=%b, want 1 9 111111",
                  exl, cause_exccode, cause_ip);
      else passed++;
      reset = 1'b1;
      #1;
      total++;
      if ({int_exc_req, epc_we, exl, cause_exccode, cause_ip, int_id} !== 17'd0)
         $display("FAIL reset_mid: got req=%b epc=%b exl=%b code=%0d ip=%b id=%0d, want all 0",
                  int_exc_req, epc_we, exl, cause_exccode, cause_ip, int_id);
      else passed++;
      hw_int = 6'd0;
      step();
      reset = 1'b0;
      exc_valid = 1'b1;
      exc_code  = 5'd3;
      #1;
      total++;
      if ({exl, int_exc_req, epc_we} !== 3'b011)
         $display("FAIL post_reset_idle: got exl=%b req=%b epc=%b, want 0 1 1",
                  exl, int_exc_req, epc_we);
      else passed++;
      exc_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      hw_int    = '0;
      im        = 6'h3F;
      ie        = 1'b1;
      m_valid   = 1'b1;
      exc_valid = 1'b0;
      exc_code  = '0;
      eret_m    = 1'b0;
      test_reset();
      test_interrupt();
      test_nested();
      test_guard();
      test_exc_beats_irq();
      test_masking();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
